// File: rtl/acs_radix_norm.sv
// acs_radix_norm: radix-2^k add-compare-select with saturating, threshold-renormalised path metrics
module acs_radix_norm #(
  parameter int STATE_BITS = 8,
  parameter int RADIX_BITS = 2,
  parameter int DIST_W     = 3,
  parameter int PM_W       = 10,
  parameter int PM_INIT    = 2 ** (PM_W - 2)
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic                                                      en_acs,
  input  logic                                                      i_valid,
  input  logic                                                      i_start,
  input  logic [(1<<STATE_BITS)-1:0][(1<<RADIX_BITS)-1:0][DIST_W-1:0] i_dist,
  output logic                                                      o_valid,
  output logic [(1<<STATE_BITS)-1:0][RADIX_BITS-1:0]                 o_dec,
  output logic [STATE_BITS-1:0]                                     o_best_st,
  output logic [PM_W-1:0]                                           o_best_pm,
  output logic                                                      o_norm
);
  localparam int NS = 1 << STATE_BITS;
  localparam int R  = 1 << RADIX_BITS;
  localparam logic [NS-1:0][PM_W-1:0] INIT_PM = {{(NS-1){PM_W'(PM_INIT)}}, PM_W'(0)};
  logic [NS-1:0][PM_W-1:0]       pm_q, base, new_pm, pm_d;
  logic [NS-1:0][RADIX_BITS-1:0] dec_d;
  logic [PM_W-1:0]               min_pm, best_pm_d;
  logic [STATE_BITS-1:0]         best_st_d;
  logic                          norm_d, fire;
  assign fire = en_acs & i_valid;
  assign base = i_start ? INIT_PM : pm_q;
  for (genvar n = 0; n < NS; n++) begin : g_ns
    localparam logic [STATE_BITS-1:0] NB = STATE_BITS'(n);
    logic [RADIX_BITS-1:0]    u;
    logic [R-1:0][PM_W-1:0]   cand;
    logic [PM_W-1:0]          sel;
    logic [RADIX_BITS-1:0]    sj;
    for (genvar b = 0; b < RADIX_BITS; b++) begin : g_u
      assign u[b] = NB[RADIX_BITS-1-b];
    end
    for (genvar j = 0; j < R; j++) begin : g_j
      localparam int P = j * (NS / R) + n / R;
      logic [PM_W:0] sum;
      assign sum     = {1'b0, base[P]} + (PM_W+1)'(i_dist[P][u]);
      assign cand[j] = sum[PM_W] ? '1 : sum[PM_W-1:0];
    end
    always_comb begin
      sel = cand[0];
      sj  = '0;
      for (int k = 1; k < R; k++)
        if (cand[k] < sel) begin
          sel = cand[k];
          sj  = RADIX_BITS'(k);
        end
    end
    assign new_pm[n] = sel;
    assign dec_d[n]  = sj;
  end
  // subtraction is uniform, so the pre-normalisation argmin is also the post-normalisation argmin
  always_comb begin
    min_pm    = new_pm[0];
    best_st_d = '0;
    for (int s = 1; s < NS; s++)
      if (new_pm[s] < min_pm) begin
        min_pm    = new_pm[s];
        best_st_d = STATE_BITS'(s);
      end
    norm_d = min_pm[PM_W-1];
    for (int s = 0; s < NS; s++)
      pm_d[s] = norm_d ? {1'b0, new_pm[s][PM_W-2:0]} : new_pm[s];
    best_pm_d = norm_d ? {1'b0, min_pm[PM_W-2:0]} : min_pm;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q      <= INIT_PM;
      o_valid   <= 1'b0;
      o_dec     <= '0;
      o_best_st <= '0;
      o_best_pm <= '0;
      o_norm    <= 1'b0;
    end else begin
      o_valid <= fire;
      o_norm  <= fire & norm_d;
      if (fire) begin
        pm_q      <= pm_d;
        o_dec     <= dec_d;
        o_best_st <= best_st_d;
        o_best_pm <= best_pm_d;
      end
    end
  end
endmodule

// File: tb/tb_acs_radix_norm.sv
// tb_acs_radix_norm: vector table, corner sequences and randomized checks against a trellis model
module tb_acs_radix_norm;
  localparam int SB = 2, RB = 1, DW = 3, PW = 6, PI = 16, NS = 4, R = 2;
  typedef logic [NS-1:0][R-1:0][DW-1:0] dist_t;
  typedef struct {
    bit        st;
    dist_t     d;
    logic [3:0] dec;
    int        bst;
    int        bpm;
    bit        nrm;
  } vec_t;
  logic clk = 0, rst = 0, en_acs = 0, i_valid = 0, i_start = 0;
  dist_t i_dist = '0;
  logic o_valid, o_norm;
  logic [NS-1:0][RB-1:0] o_dec;
  logic [SB-1:0] o_best_st;
  logic [PW-1:0] o_best_pm;
  logic [NS-1:0][R-1:0][5:0] s_dist = '0;
  logic s_valid, s_norm;
  logic [NS-1:0][RB-1:0] s_dec;
  logic [SB-1:0] s_best_st;
  logic [PW-1:0] s_best_pm;
  int checks = 0, errors = 0;
  int m_pm[NS], m_dec[NS];
  int m_best_st, m_best_pm, m_valid, m_norm;
  vec_t tv[6];
  bit seen;
  always #5 clk = ~clk;
  acs_radix_norm #(.STATE_BITS(SB), .RADIX_BITS(RB), .DIST_W(DW), .PM_W(PW), .PM_INIT(PI)) dut (
    .clk(clk), .rst(rst), .en_acs(en_acs), .i_valid(i_valid), .i_start(i_start), .i_dist(i_dist),
    .o_valid(o_valid), .o_dec(o_dec), .o_best_st(o_best_st), .o_best_pm(o_best_pm), .o_norm(o_norm));
  acs_radix_norm #(.STATE_BITS(SB), .RADIX_BITS(RB), .DIST_W(6), .PM_W(PW), .PM_INIT(PI)) dut_sat (
    .clk(clk), .rst(rst), .en_acs(en_acs), .i_valid(i_valid), .i_start(i_start), .i_dist(s_dist),
    .o_valid(s_valid), .o_dec(s_dec), .o_best_st(s_best_st), .o_best_pm(s_best_pm), .o_norm(s_norm));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < RB; b++) r = (r << 1) | ((v >> b) & 1);
    return r;
  endfunction
  function automatic dist_t dv(input int a0, a1, b0, b1, c0, c1, e0, e1);
    dist_t r;
    r[0][0] = DW'(a0); r[0][1] = DW'(a1); r[1][0] = DW'(b0); r[1][1] = DW'(b1);
    r[2][0] = DW'(c0); r[2][1] = DW'(c1); r[3][0] = DW'(e0); r[3][1] = DW'(e1);
    return r;
  endfunction
  function automatic dist_t dall(input int v);
    return dv(v, v, v, v, v, v, v, v);
  endfunction
  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_pm[s]  = (s == 0) ? 0 : PI;
      m_dec[s] = 0;
    end
    m_best_st = 0; m_best_pm = 0; m_valid = 0; m_norm = 0;
  endtask
  task automatic model_fire(input bit st);
    int base[NS], nw[NS];
    int mn, c, p;
    for (int s = 0; s < NS; s++) base[s] = st ? ((s == 0) ? 0 : PI) : m_pm[s];
    for (int ns = 0; ns < NS; ns++)
      for (int j = 0; j < R; j++) begin
        p = j * (NS / R) + ns / R;
        c = base[p] + int'(i_dist[p][bitrev(ns % R)]);
        if (c > 2 ** PW - 1) c = 2 ** PW - 1;
        if (j == 0 || c < nw[ns]) begin
          nw[ns] = c;
          m_dec[ns] = j;
        end
      end
    mn = nw[0];
    for (int s = 1; s < NS; s++) if (nw[s] < mn) mn = nw[s];
    m_norm = (mn >= 2 ** (PW - 1)) ? 1 : 0;
    m_best_st = -1;
    for (int s = 0; s < NS; s++) begin
      m_pm[s] = nw[s] - (m_norm ? 2 ** (PW - 1) : 0);
      if (m_best_st < 0 && nw[s] == mn) m_best_st = s;
    end
    m_best_pm = m_pm[m_best_st];
    m_valid = 1;
  endtask
  function automatic int exp_dec();
    int r = 0;
    for (int s = 0; s < NS; s++) r |= m_dec[s] << (s * RB);
    return r;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(o_valid), m_valid);
    chk({tag, ".norm"}, 32'(o_norm), m_norm);
    chk({tag, ".dec"}, 32'(o_dec), exp_dec());
    chk({tag, ".best_st"}, 32'(o_best_st), m_best_st);
    chk({tag, ".best_pm"}, 32'(o_best_pm), m_best_pm);
    for (int s = 0; s < NS; s++) chk({tag, ".pm"}, 32'(dut.pm_q[s]), m_pm[s]);
  endtask
  task automatic step(input bit v, input bit en, input bit st, input string tag);
    i_valid = v; en_acs = en; i_start = st;
    if (v && en) model_fire(st);
    else begin
      m_valid = 0;
      m_norm  = 0;
    end
    @(negedge clk);
    check_all(tag);
  endtask
  initial begin
    tv[0] = '{1, dall(1), 4'b0000, 0, 1, 0};
    tv[1] = '{0, dall(0), 4'b0000, 0, 1, 0};
    tv[2] = '{0, dall(4), 4'b0000, 0, 5, 0};
    tv[3] = '{0, dall(2), 4'b0000, 0, 7, 0};
    tv[4] = '{0, dv(3, 3, 2, 2, 0, 0, 2, 2), 4'b0011, 0, 7, 0};
    tv[5] = '{0, dv(4, 5, 7, 1, 3, 0, 0, 6), 4'b0110, 3, 8, 0};
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("sat_reset.valid", 32'(s_valid), 0);
    rst = 1;
    step(0, 1, 0, "idle0");
    for (int i = 0; i < 6; i++) begin
      i_dist = tv[i].d;
      step(1, 1, tv[i].st, "vec_model");
      chk("vec.valid", 32'(o_valid), 1);
      chk("vec.dec", 32'(o_dec), 32'(tv[i].dec));
      chk("vec.best_st", 32'(o_best_st), tv[i].bst);
      chk("vec.best_pm", 32'(o_best_pm), tv[i].bpm);
      chk("vec.norm", 32'(o_norm), 32'(tv[i].nrm));
    end
    i_dist = dall(3);
    repeat (3) step(0, 1, 0, "hold");
    step(1, 0, 0, "en_low");
    i_dist = dall(1);
    step(1, 1, 1, "restart");
    chk("restart.best_pm", 32'(o_best_pm), 1);
    i_dist = dall(7);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1, 1, 0, "renorm_run");
      if (m_norm) begin
        seen = 1;
        chk("renorm.flag", 32'(o_norm), 1);
        chk("renorm.pm", 32'(o_best_pm), 4);
        step(1, 1, 0, "post_norm");
        chk("post_norm.flag", 32'(o_norm), 0);
      end
    end
    chk("renorm_seen", 32'(seen), 1);
    for (int s = 0; s < NS; s++) begin
      s_dist[s][0] = (s == 1) ? 6'd63 : (s == 3) ? 6'd40 : 6'd0;
      s_dist[s][1] = (s == 1 || s == 3) ? 6'd63 : 6'd0;
    end
    i_dist = dall(2);
    step(1, 1, 1, "sat1_main");
    chk("sat1.valid", 32'(s_valid), 1);
    chk("sat1.dec", 32'(s_dec), 32'b0100);
    chk("sat1.pm2", 32'(dut_sat.pm_q[2]), 56);
    chk("sat1.pm3", 32'(dut_sat.pm_q[3]), 63);
    chk("sat1.best_pm", 32'(s_best_pm), 0);
    chk("sat1.norm", 32'(s_norm), 0);
    for (int s = 0; s < NS; s++) begin
      s_dist[s][0] = (s == 3) ? 6'd0 : (s == 2) ? 6'd40 : 6'd63;
      s_dist[s][1] = s_dist[s][0];
    end
    step(1, 1, 0, "sat2_main");
    chk("sat2.norm", 32'(s_norm), 1);
    chk("sat2.best_st", 32'(s_best_st), 0);
    chk("sat2.best_pm", 32'(s_best_pm), 31);
    for (int s = 0; s < NS; s++) chk("sat2.pm", 32'(dut_sat.pm_q[s]), 31);
    #2 rst = 0;
    #1 model_reset();
    check_all("async_rst");
    chk("async_rst.sat_pm", 32'(dut_sat.pm_q[2]), PI);
    #1 rst = 1;
    i_dist = dall(1);
    step(1, 1, 0, "fresh");
    chk("fresh.best_pm", 32'(o_best_pm), 1);
    for (int k = 0; k < 400; k++) begin
      for (int s = 0; s < NS; s++)
        for (int u = 0; u < R; u++) i_dist[s][u] = DW'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
